// File: rtl/tset_pkg.sv
// Shared constants and FSM state type for the Tset lookup engine.
// The widths here are the default build; the derived offsets describe the PRF output split.
package tset_pkg;

   localparam int B_BITS_DEF = 8;
   localparam int S_BITS_DEF = 2;
   localparam int LBL_W_DEF  = 32;
   localparam int VAL_W_DEF  = 64;
   localparam int MAX_I_DEF  = 255;

   localparam int ENT_W = LBL_W_DEF + 1 + VAL_W_DEF;
   localparam int L_LSB = B_BITS_DEF;
   localparam int K_LSB = B_BITS_DEF + LBL_W_DEF;
   localparam int K_W   = VAL_W_DEF + 1;

   typedef enum logic [2:0] {
      IDLE,
      PRF,
      RD,
      CMP,
      EMIT,
      FIN
   } state_t;

endpackage

// File: rtl/tset_prf_split.sv
// Splits a PRF block into bucket index, label and mask, and holds them when the AES
// result is accepted so the bucket scan works from stable values.
module tset_prf_split #(
   parameter int B_BITS = 8,
   parameter int LBL_W  = 32,
   parameter int VAL_W  = 64
) (
   input  logic              clk,
   input  logic              capture,
   input  logic [127:0]      dout,
   output logic [B_BITS-1:0] b_p1,
   output logic [LBL_W-1:0]  lbl_p1,
   output logic [VAL_W:0]    k_p1
);

   localparam int FIELD_END = B_BITS + LBL_W + VAL_W + 1;

   if (FIELD_END > 128) begin : g_width_check
      $error("tset_prf_split: B_BITS+LBL_W+VAL_W+1 exceeds the 128-bit PRF block");
   end

   if (FIELD_END < 128) begin : g_spare
      logic unused_hi;
      assign unused_hi = ^dout[127:FIELD_END];
   end

   logic [B_BITS-1:0] b_p0;
   logic [LBL_W-1:0]  lbl_p0;
   logic [VAL_W:0]    k_p0;

   assign b_p0   = dout[B_BITS-1:0];
   assign lbl_p0 = dout[B_BITS+LBL_W-1:B_BITS];
   assign k_p0   = dout[B_BITS+LBL_W+VAL_W:B_BITS+LBL_W];

   // p0 -> p1: hold the split fields for the whole bucket scan
   always_ff @(posedge clk) begin
      if (capture) begin
         b_p1   <= b_p0;
         lbl_p1 <= lbl_p0;
         k_p1   <= k_p0;
      end
   end

endmodule

// File: rtl/tset_retrieve.sv
// Tset lookup engine: iterates PRF(stag, i), scans the addressed bucket for the label,
// unmasks the matching entry and streams records until the continue bit clears.
module tset_retrieve
   import tset_pkg::*;
#(
   parameter int B_BITS = B_BITS_DEF,
   parameter int S_BITS = S_BITS_DEF,
   parameter int LBL_W  = LBL_W_DEF,
   parameter int VAL_W  = VAL_W_DEF,
   parameter int MAX_I  = MAX_I_DEF
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     start,
   input  logic [127:0]             stag,
   output logic                     busy,
   output logic                     aes_req,
   output logic [127:0]             aes_key,
   output logic [127:0]             aes_din,
   input  logic                     aes_ack,
   input  logic [127:0]             aes_dout,
   output logic                     mem_rd_en,
   output logic [B_BITS+S_BITS-1:0] mem_addr,
   input  logic [LBL_W+VAL_W:0]     mem_rd_data,
   output logic                     rec_valid,
   input  logic                     rec_ready,
   output logic [VAL_W-1:0]         rec_data,
   output logic                     rec_last,
   output logic                     done,
   output logic                     err
);

   localparam int I_W = $clog2(MAX_I + 1);
   localparam logic [S_BITS-1:0] SLOT_LAST = '1;

   state_t            state;
   state_t            nxt;
   logic [I_W-1:0]    iter;
   logic [S_BITS-1:0] slot;
   logic [B_BITS-1:0] b_p1;
   logic [LBL_W-1:0]  lbl_p1;
   logic [VAL_W:0]    k_p1;
   logic              beta_p2;
   logic [VAL_W-1:0]  val_p2;
   logic              capture;
   logic              hit;
   logic              last_iter;

   assign capture   = (state == PRF) && aes_ack;
   assign hit       = (mem_rd_data[LBL_W+VAL_W:VAL_W+1] == lbl_p1);
   assign last_iter = (iter == I_W'(MAX_I));
   assign aes_din   = 128'(iter);

   tset_prf_split #(
      .B_BITS (B_BITS),
      .LBL_W  (LBL_W),
      .VAL_W  (VAL_W)
   ) u_split (
      .clk     (clk),
      .capture (capture),
      .dout    (aes_dout),
      .b_p1    (b_p1),
      .lbl_p1  (lbl_p1),
      .k_p1    (k_p1)
   );

   always_ff @(posedge clk) begin
      if (RST) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt       = state;
      busy      = (state != IDLE);
      aes_req   = 1'b0;
      mem_rd_en = 1'b0;
      rec_valid = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) nxt = PRF;
         PRF: begin
            aes_req = 1'b1;
            if (aes_ack) nxt = RD;
         end
         RD: begin
            mem_rd_en = 1'b1;
            nxt       = CMP;
         end
         CMP: begin
            if (hit)                    nxt = EMIT;
            else if (slot != SLOT_LAST) nxt = RD;
            else                        nxt = FIN;
         end
         EMIT: begin
            rec_valid = 1'b1;
            if (rec_ready) nxt = (beta_p2 && !last_iter) ? PRF : FIN;
         end
         FIN: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Outputs are forced to zero outside the states that own them so reset leaves them all low.
   assign mem_addr = mem_rd_en ? {b_p1, slot} : '0;
   assign rec_data = rec_valid ? val_p2 : '0;
   assign rec_last = rec_valid & ~beta_p2;

   always_ff @(posedge clk) begin
      if (RST) begin
         iter    <= '0;
         slot    <= '0;
         err     <= 1'b0;
         aes_key <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  aes_key <= stag;
                  iter    <= '0;
                  err     <= 1'b0;
               end
            end
            PRF: if (aes_ack) slot <= '0;
            CMP: begin
               if (!hit) begin
                  if (slot != SLOT_LAST) slot <= slot + 1'b1;
                  else                   err  <= 1'b1;
               end
            end
            EMIT: begin
               if (rec_ready && beta_p2) begin
                  if (last_iter) err  <= 1'b1;
                  else           iter <= iter + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // p1 -> p2: unmask the entry read in this cycle; EMIT holds it until the handshake
   always_ff @(posedge clk) begin
      if (state == CMP) {beta_p2, val_p2} <= mem_rd_data[VAL_W:0] ^ k_p1;
   end

endmodule

// File: tb/tb_tset_retrieve.sv
// Bench for tset_retrieve: XOR-based PRF stub, Tset memory model and a search-level
// reference model that walks the chain directly from the memory contents.
module tb_tset_retrieve;

   localparam int EW = tset_pkg::ENT_W;

   logic          clk = 1'b0;
   logic          RST;
   logic          start;
   logic [127:0]  stag;
   logic          busy;
   logic          aes_req;
   logic [127:0]  aes_key;
   logic [127:0]  aes_din;
   logic          aes_ack;
   logic [127:0]  aes_dout;
   logic          mem_rd_en;
   logic [9:0]    mem_addr;
   logic [EW-1:0] mem_rd_data;
   logic          rec_valid;
   logic          rec_ready;
   logic [63:0]   rec_data;
   logic          rec_last;
   logic          done;
   logic          err;

   tset_retrieve dut (
      .clk         (clk),
      .RST         (RST),
      .start       (start),
      .stag        (stag),
      .busy        (busy),
      .aes_req     (aes_req),
      .aes_key     (aes_key),
      .aes_din     (aes_din),
      .aes_ack     (aes_ack),
      .aes_dout    (aes_dout),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_data    (rec_data),
      .rec_last    (rec_last),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   logic [EW-1:0] mem [0:1023];
   logic [9:0]    rd_log [$];
   int            aes_cnt;

   logic [63:0]   got_val [$];
   logic          got_last [$];
   logic [63:0]   exp_val [$];
   logic          exp_last [$];
   logic          exp_err;
   int            exp_reads;
   int            done_cnt;
   bit            timed_out;
   int            stall_len = 0;
   bit            stall_ok;
   bit            stall_noreq;
   bit            inject_en = 0;
   logic [127:0]  inject_tag;
   bit            key_ok;

   assign aes_dout = aes_key ^ aes_din;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= mem[mem_addr];
         rd_log.push_back(mem_addr);
      end
   end

   // PRF stub: acknowledges a held request three cycles after it appears
   always @(posedge clk) begin
      if (RST) begin
         aes_ack <= 1'b0;
         aes_cnt <= 0;
      end else begin
         aes_ack <= 1'b0;
         if (aes_req && !aes_ack) begin
            if (aes_cnt == 2) begin
               aes_ack <= 1'b1;
               aes_cnt <= 0;
            end else begin
               aes_cnt <= aes_cnt + 1;
            end
         end else begin
            aes_cnt <= 0;
         end
      end
   end

   task automatic fill_labels(input logic [31:0] lbl);
      for (int a = 0; a < 1024; a++) mem[a] = {lbl, 1'b0, 64'h0};
   endtask

   task automatic preload_chain();
      fill_labels(32'hFFFF_FFFF);
      mem[2] = {32'h0, 1'b1, 64'h1111};
      mem[4] = {32'h0, 1'b0, 64'h2222};
   endtask

   // Reference: walk i = 0.. over PRF = tag ^ i, first label match per bucket, stop on beta=0.
   task automatic model(input logic [127:0] tag);
      logic [127:0] d;
      logic [7:0]   b;
      logic [31:0]  l;
      logic [64:0]  k;
      logic [64:0]  ent;
      bit           found;
      exp_val.delete();
      exp_last.delete();
      exp_err   = 1'b0;
      exp_reads = 0;
      ent       = '0;
      for (int it = 0; it <= 255; it++) begin
         d = tag ^ {120'h0, 8'(it)};
         b = d[7:0];
         l = d[39:8];
         k = d[104:40];
         found = 0;
         for (int s = 0; s < 4; s++) begin
            if (!found) begin
               exp_reads++;
               if (mem[{b, 2'(s)}][96:65] == l) begin
                  found = 1;
                  ent   = mem[{b, 2'(s)}][64:0] ^ k;
               end
            end
         end
         if (!found) begin
            exp_err = 1'b1;
            break;
         end
         exp_val.push_back(ent[63:0]);
         exp_last.push_back(!ent[64]);
         if (!ent[64]) break;
         if (it == 255) begin
            exp_err = 1'b1;
            break;
         end
      end
   endtask

   function automatic bit recs_match();
      if (got_val.size() != exp_val.size()) return 0;
      foreach (got_val[n]) begin
         if (got_val[n] !== exp_val[n] || got_last[n] !== exp_last[n]) return 0;
      end
      return 1;
   endfunction

   task automatic run_search(input logic [127:0] tag, input int ready_pct);
      bit          r;
      bit          prev_rd;
      bit          inj_done;
      int          stalled;
      logic [63:0] held;
      got_val.delete();
      got_last.delete();
      rd_log.delete();
      done_cnt    = 0;
      timed_out   = 1;
      stall_ok    = 1;
      stall_noreq = 1;
      key_ok      = 1;
      prev_rd     = 0;
      inj_done    = 0;
      stalled     = 0;
      held        = '0;
      @(negedge clk);
      stag  = tag;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (inject_en && prev_rd && !inj_done) begin
            start    = 1'b1;
            stag     = inject_tag;
            inj_done = 1;
         end else begin
            start = 1'b0;
         end
         if (aes_key !== tag) key_ok = 0;
         if (rec_valid && stalled < stall_len) begin
            if (stalled == 0) held = rec_data;
            else if (rec_data !== held) stall_ok = 0;
            if (aes_req) stall_noreq = 0;
            stalled++;
            r = 0;
         end else begin
            r = ($urandom_range(99) < ready_pct);
         end
         rec_ready = r;
         if (rec_valid && r) begin
            got_val.push_back(rec_data);
            got_last.push_back(rec_last);
         end
         if (done) begin
            done_cnt++;
            timed_out = 0;
            break;
         end
         prev_rd = mem_rd_en;
         @(negedge clk);
      end
      start     = 1'b0;
      rec_ready = 1'b0;
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL search_timeout: no done pulse within 20000 cycles");
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done: done=%b busy=%b, required 0 0 after end", done, busy);
      end
   endtask

   task automatic test_reset();
      RST       = 1'b1;
      start     = 1'b0;
      stag      = '0;
      rec_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, aes_req, mem_rd_en, rec_valid, rec_last, done, err} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {busy, aes_req, mem_rd_en, rec_valid, rec_last, done, err});
      end
      checks++;
      if (aes_key !== '0 || aes_din !== '0) begin
         errors++;
         $display("FAIL reset_aes: key=%h din=%h required 0", aes_key, aes_din);
      end
      checks++;
      if (mem_addr !== '0 || rec_data !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h data=%h required 0", mem_addr, rec_data);
      end
      RST = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b required 0", busy);
      end
   endtask

   task automatic test_chain();
      preload_chain();
      model('0);
      run_search('0, 100);
      checks++;
      if (got_val.size() != 2 || got_val[0] !== 64'h1111 || got_val[1] !== 64'h2222) begin
         errors++;
         $display("FAIL chain_data: got %0d records first=%h, required 2 records 1111 2222",
                  got_val.size(), (got_val.size() > 0) ? got_val[0] : 64'h0);
      end
      checks++;
      if (got_last.size() != 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
         errors++;
         $display("FAIL chain_last: got %0d flags, required last only on record 2", got_last.size());
      end
      checks++;
      if (err !== 1'b0 || rd_log.size() != 4) begin
         errors++;
         $display("FAIL chain_err_reads: err=%b reads=%0d, required 0 and 4", err, rd_log.size());
      end
      checks++;
      if (!recs_match()) begin
         errors++;
         $display("FAIL chain_model: got %0d records, model %0d", got_val.size(), exp_val.size());
      end
   endtask

   task automatic test_masking();
      logic [127:0] tag;
      tag = {23'h0, 1'b0, {8{8'hA5}}, 32'hDEAD_BEEF, 8'h00};
      fill_labels(32'hFFFF_FFFF);
      mem[0] = {32'hDEAD_BEEF, 1'b0, {8{8'h5A}}};
      run_search(tag, 100);
      checks++;
      if (got_val.size() != 1 || got_val[0] !== 64'hFFFF_FFFF_FFFF_FFFF || got_last[0] !== 1'b1) begin
         errors++;
         $display("FAIL mask_unmask: got %0d records first=%h, required 1 record ffffffffffffffff last=1",
                  got_val.size(), (got_val.size() > 0) ? got_val[0] : 64'h0);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL mask_err: err=%b required 0", err);
      end
   endtask

   task automatic test_miss();
      bit addr_ok;
      fill_labels(32'hFFFF_FFFF);
      run_search('0, 100);
      addr_ok = (rd_log.size() == 4);
      foreach (rd_log[n]) if (rd_log[n] !== 10'(n)) addr_ok = 0;
      checks++;
      if (!addr_ok) begin
         errors++;
         $display("FAIL miss_reads: %0d reads, required addresses 0..3", rd_log.size());
      end
      checks++;
      if (got_val.size() != 0 || err !== 1'b1) begin
         errors++;
         $display("FAIL miss_result: records=%0d err=%b, required 0 and 1", got_val.size(), err);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL miss_sticky: err=%b required 1", err);
      end
   endtask

   task automatic test_backpressure();
      preload_chain();
      stall_len = 10;
      run_search('0, 100);
      stall_len = 0;
      checks++;
      if (!stall_ok || !stall_noreq) begin
         errors++;
         $display("FAIL bp_stable: data_stable=%b no_req=%b, required 1 1", stall_ok, stall_noreq);
      end
      checks++;
      if (got_val.size() != 2 || got_val[0] !== 64'h1111 || got_val[1] !== 64'h2222) begin
         errors++;
         $display("FAIL bp_records: got %0d records, required 1111 2222", got_val.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] tag;
      bit           seen;
      int           stray;
      tag = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      preload_chain();
      @(negedge clk);
      stag  = tag;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 0;
      for (int c = 0; c < 50; c++) begin
         if (aes_req) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rst_mid_req: aes_req=0 after 50 cycles, required 1");
      end
      RST = 1'b1;
      @(negedge clk);
      checks++;
      if ({aes_req, rec_valid, busy, done, mem_rd_en, err} !== 6'b0 || aes_key !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: ctrl=%b key=%h, required all 0",
                  {aes_req, rec_valid, busy, done, mem_rd_en, err}, aes_key);
      end
      RST   = 1'b0;
      stray = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL rst_mid_done: %0d done pulses, required 0", stray);
      end
      model('0);
      run_search('0, 100);
      checks++;
      if (!recs_match() || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_restart: records=%0d err=%b, required %0d and 0",
                  got_val.size(), err, exp_val.size());
      end
   endtask

   task automatic test_start_busy();
      preload_chain();
      model('0);
      inject_tag = {$urandom, $urandom, $urandom, $urandom} | 128'h100;
      inject_en  = 1;
      run_search('0, 100);
      inject_en  = 0;
      checks++;
      if (!key_ok) begin
         errors++;
         $display("FAIL busy_key: aes_key=%h changed, required 0", aes_key);
      end
      checks++;
      if (!recs_match() || err !== 1'b0) begin
         errors++;
         $display("FAIL busy_records: records=%0d err=%b, required %0d and 0",
                  got_val.size(), err, exp_val.size());
      end
   endtask

   task automatic test_max_i();
      fill_labels(32'hFFFF_FFFF);
      for (int b = 0; b < 256; b++) mem[b*4] = {32'h0, 1'b1, 56'h0, 8'(b)};
      model('0);
      run_search('0, 100);
      checks++;
      if (got_val.size() != 256 || err !== 1'b1) begin
         errors++;
         $display("FAIL maxi_abort: records=%0d err=%b, required 256 and 1", got_val.size(), err);
      end
      checks++;
      if (!recs_match()) begin
         errors++;
         $display("FAIL maxi_model: got %0d records, model %0d", got_val.size(), exp_val.size());
      end
   endtask

   task automatic test_random();
      logic [127:0] tag;
      logic [127:0] d;
      logic [64:0]  ent;
      int           len;
      int           s;
      bit           miss;
      for (int t = 0; t < 8; t++) begin
         tag = {$urandom, $urandom, $urandom, $urandom};
         for (int a = 0; a < 1024; a++) mem[a] = {$urandom, 1'($urandom), $urandom, $urandom};
         len  = $urandom_range(1, 4);
         miss = ($urandom_range(0, 3) == 0);
         for (int it = 0; it < len; it++) begin
            if (miss && it == len - 1) continue;
            d   = tag ^ {120'h0, 8'(it)};
            s   = $urandom_range(0, 3);
            ent = {(it != len - 1) ? 1'b1 : 1'b0, $urandom, $urandom} ^ d[104:40];
            mem[{d[7:0], 2'(s)}] = {d[39:8], ent};
            if (s < 3 && $urandom_range(0, 1) == 1) mem[{d[7:0], 2'(s + 1)}] = {d[39:8], ~ent};
         end
         model(tag);
         run_search(tag, 60);
         checks++;
         if (!recs_match()) begin
            errors++;
            $display("FAIL rand_records[%0d]: got %0d records, model %0d", t, got_val.size(), exp_val.size());
         end
         checks++;
         if (err !== exp_err || rd_log.size() != exp_reads) begin
            errors++;
            $display("FAIL rand_err_reads[%0d]: err=%b reads=%0d, required %b and %0d",
                     t, err, rd_log.size(), exp_err, exp_reads);
         end
      end
   endtask

   initial begin
      RST       = 1'b1;
      start     = 1'b0;
      stag      = '0;
      rec_ready = 1'b0;
      test_reset();
      test_miss();
      test_chain();
      test_masking();
      test_backpressure();
      test_reset_mid();
      test_start_busy();
      test_max_i();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
